// File: rtl/divisor_sequencial_if.sv
// Operand/result bundle for the sequential divider.
// master issues start and operands; slave returns quotient, remainder and status.
interface divisor_sequencial_if #(
    parameter int WIDTH = 5
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero
    );
endinterface

// File: rtl/divisor_sequencial.sv
// Unsigned restoring divider that produces one quotient bit per CLOCK_50 cycle.
// Results are registered and held until the next operation completes.
//
//  state | meaning
//  IDLE  | waiting for start; operands captured on the accepting edge
//  RUN   | one shift/compare/subtract step per cycle, WIDTH steps in total
//  DONE  | one-cycle done pulse; results already loaded
module divisor_sequencial #(
    parameter int WIDTH = 5
) (
    input  logic                 CLOCK_50,
    input  logic                 RESET_N,
    divisor_sequencial_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH:0]   r_r;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_dbz;

    logic [WIDTH:0]   w_r_shift;
    logic             w_ge;
    logic [WIDTH:0]   w_r_next;
    logic [WIDTH-1:0] w_q_next;
    logic             w_div_zero;
    logic             w_last;

    // One restoring step: shift the next dividend bit into R, subtract D if it fits.
    assign w_r_shift  = {r_r[WIDTH-1:0], r_q[WIDTH-1]};
    assign w_ge       = (w_r_shift >= {1'b0, r_d});
    assign w_r_next   = w_ge ? (w_r_shift - {1'b0, r_d}) : w_r_shift;
    assign w_q_next   = {r_q[WIDTH-2:0], w_ge};
    assign w_div_zero = (bus.divisor == '0);
    assign w_last     = (r_cnt == CW'(1));

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_next = w_div_zero ? DONE : RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_q         <= '0;
            r_d         <= '0;
            r_r         <= '0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        if (w_div_zero) begin
                            r_quotient  <= '1;
                            r_remainder <= bus.dividend;
                            r_dbz       <= 1'b1;
                        end else begin
                            r_q   <= bus.dividend;
                            r_d   <= bus.divisor;
                            r_r   <= '0;
                            r_cnt <= CW'(WIDTH);
                        end
                    end
                end
                RUN: begin
                    r_q   <= w_q_next;
                    r_r   <= w_r_next;
                    r_cnt <= r_cnt - CW'(1);
                    if (w_last) begin
                        r_quotient  <= w_q_next;
                        r_remainder <= w_r_next[WIDTH-1:0];
                        r_dbz       <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_dbz;
    assign bus.busy        = (r_state == RUN);
    assign bus.done        = (r_state == DONE);
endmodule

// File: tb/tb_divisor_sequencial.sv
// Directed test of divisor_sequencial at WIDTH=5: arithmetic, latency, divide-by-zero,
// ignored mid-run start, back-to-back throughput and asynchronous reset abort.
module tb_divisor_sequencial;
    localparam int WIDTH = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   prev_q   = 0;
    int   prev_r   = 0;

    divisor_sequencial_if #(.WIDTH(WIDTH)) bus ();

    divisor_sequencial #(.WIDTH(WIDTH)) dut (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .bus      (bus.slave)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input int a, input int b, input int eq,
                          input int er, input int edbz, input bit disturb);
        int lat;
        int busy_n;
        int extra_done;
        lat        = 0;
        busy_n     = 0;
        extra_done = 0;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = WIDTH'(a);
        bus.divisor  = WIDTH'(b);
        @(posedge clk); #1;
        bus.start = 1'b0;
        while (bus.done !== 1'b1 && lat < 3 * WIDTH) begin
            if (bus.busy === 1'b1) busy_n++;
            if (lat == 0) begin
                check({tag, "_hold_q"}, 32'(bus.quotient), 32'(prev_q));
                check({tag, "_hold_r"}, 32'(bus.remainder), 32'(prev_r));
            end
            if (disturb && lat == 1) begin
                bus.start    = 1'b1;
                bus.dividend = 5'd31;
                bus.divisor  = 5'd1;
            end
            if (disturb && lat == 3) bus.start = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), (b == 0) ? 32'd0 : 32'(WIDTH));
        check({tag, "_busy_cycles"}, 32'(busy_n), (b == 0) ? 32'd0 : 32'(WIDTH));
        check({tag, "_done"}, 32'(bus.done), 32'd1);
        check({tag, "_busy_in_done"}, 32'(bus.busy), 32'd0);
        check({tag, "_quotient"}, 32'(bus.quotient), 32'(eq));
        check({tag, "_remainder"}, 32'(bus.remainder), 32'(er));
        check({tag, "_dbz"}, 32'(bus.div_by_zero), 32'(edbz));
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
        check({tag, "_q_stable"}, 32'(bus.quotient), 32'(eq));
        if (disturb) begin
            for (int i = 0; i < 10; i++) begin
                @(posedge clk); #1;
                if (bus.done === 1'b1) extra_done++;
            end
            check({tag, "_extra_done"}, 32'(extra_done), 32'd0);
        end
        prev_q = eq;
        prev_r = er;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int dones;
        int last_c;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        #2 rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("rst_quotient", 32'(bus.quotient), 32'd0);
        check("rst_remainder", 32'(bus.remainder), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_dbz", 32'(bus.div_by_zero), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        run_op("d29_4",  29, 4,  7,  1,  0, 1'b0);
        run_op("d31_1",  31, 1,  31, 0,  0, 1'b0);
        run_op("d3_7",   3,  7,  0,  3,  0, 1'b0);
        run_op("d0_5",   0,  5,  0,  0,  0, 1'b0);
        run_op("d31_31", 31, 31, 1,  0,  0, 1'b0);
        run_op("d12_0",  12, 0,  31, 12, 1, 1'b0);
        run_op("d10_3",  10, 3,  3,  1,  0, 1'b0);
        run_op("d20_6",  20, 6,  3,  2,  0, 1'b1);

        // start held high: operations should retire every WIDTH+2 cycles
        dones  = 0;
        last_c = -1;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 5'd25;
        bus.divisor  = 5'd4;
        for (int c = 0; c < 22; c++) begin
            @(posedge clk); #1;
            check("held_busy_done_excl", 32'(bus.busy & bus.done), 32'd0);
            if (bus.done === 1'b1) begin
                dones++;
                check("held_quotient", 32'(bus.quotient), 32'd6);
                check("held_remainder", 32'(bus.remainder), 32'd1);
                if (last_c < 0) check("held_first_done", 32'(c), 32'(WIDTH));
                else            check("held_interval", 32'(c - last_c), 32'(WIDTH + 2));
                last_c = c;
            end
        end
        check("held_done_count", 32'(dones), 32'd3);
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        // reset during the third RUN cycle of 31/2
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 5'd31;
        bus.divisor  = 5'd2;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("abort_busy_before", 32'(bus.busy), 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #4;
        rst_n = 1'b0;
        #1;
        check("abort_quotient", 32'(bus.quotient), 32'd0);
        check("abort_remainder", 32'(bus.remainder), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_dbz", 32'(bus.div_by_zero), 32'd0);
        dones = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) dones++;
        end
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);
        prev_q = 0;
        prev_r = 0;
        run_op("d31_2", 31, 2, 15, 1, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
